store_trace_checker: RTL and testbench

- Synthesizable store-bus checker downstream of the pipelined MIPS top; consumes the data-memory write port (memwrite, dataadr, writedata) every cycle.
- Compares committed stores, in order, against an expected trace loaded beforehand; flags pass/fail with diagnostics.
- Replaces negedge $display checks so FPGA runs and simulation share one pass/fail criterion.

---
 rtl/store_trace_checker.sv | 202 ++++++++++++++++++++
 tb/tb_store_trace_checker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : store_trace_checker
// Description : Watches the data-memory write port of the pipelined MIPS core
//               and compares every committed store, in order, against an
//               expected trace loaded beforehand.  It produces one sticky
//               pass/fail verdict with diagnostics, so FPGA runs and
//               simulation share the same criterion.
//
//   Optional feature macro: STC_TIMEOUT_EN
//     When defined, a watchdog fails the run once TIMEOUT cycles have been
//     spent in RUN without completing the trace.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     memwrite/dataadr/     store-commit strobe, byte address and data
//       writedata
//     exp_we/exp_addr/      load one expected {addr, data} entry (LOAD only)
//       exp_data
//     start                 one-cycle pulse, LOAD -> RUN (or PASS if empty)
//     exp_full              table holds DEPTH entries
//     done/pass/fail        sticky verdict flags
//     timeout               fail was caused by the watchdog
//     err_index/err_addr/   diagnostics latched at the failing cycle
//       err_data
//     cycle_count           cycles spent in RUN (saturating, frozen at verdict)
//
// Revision    : 1.0 - initial release
// ============================================================================
module store_trace_checker #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] IGNORE_ADDR  = 32'd80,
    parameter logic        IGNORE_VALID = 1'b1,
    parameter logic [31:0] TIMEOUT      = 32'd10000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    input  logic                     exp_we,
    input  logic [31:0]              exp_addr,
    input  logic [31:0]              exp_data,
    input  logic                     start,
    output logic                     exp_full,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] err_index,
    output logic [31:0]              err_addr,
    output logic [31:0]              err_data,
    output logic [31:0]              cycle_count
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } stcState_t;

    stcState_t          r_state;
    stcState_t          w_nextState;
    logic [c_CNT_W-1:0] r_loadCount;
    logic [c_IDX_W-1:0] r_ptr;
    logic [31:0]        r_tblAddr [DEPTH];
    logic [31:0]        r_tblData [DEPTH];
    logic [31:0]        r_cycleCount;
    logic [c_IDX_W-1:0] r_errIndex;
    logic [31:0]        r_errAddr;
    logic [31:0]        r_errData;

    logic w_doWrite;
    logic w_match;
    logic w_lastEntry;
    logic w_ignore;
    logic w_advance;
    logic w_latchErr;
    logic w_latchTimeout;

    assign exp_full  = (r_loadCount == c_DEPTH);
    assign w_doWrite = (r_state == LOAD) && exp_we && !exp_full;

    assign w_match     = memwrite && (dataadr == r_tblAddr[r_ptr])
                                  && (writedata == r_tblData[r_ptr]);
    // Only evaluated in RUN, where the load count is at least one.
    assign w_lastEntry = ({1'b0, r_ptr} == (r_loadCount - 1'b1));
    assign w_ignore    = memwrite && IGNORE_VALID && (dataadr == IGNORE_ADDR);

`ifdef STC_TIMEOUT_EN
    logic r_timeout;
    logic w_timeoutHit;
    assign w_timeoutHit = (r_cycleCount == (TIMEOUT - 32'd1));
    assign timeout      = r_timeout;
`else
    // Watchdog absent: TIMEOUT has no effect; the reference keeps the
    // parameter meaningful in both builds without changing the result.
    assign timeout = (TIMEOUT == 32'd0) & 1'b0;
`endif

    // Next-state and control decode. In RUN the priority is: completing
    // match, watchdog, ordinary match, ignored scratch write, mismatch.
    always_comb begin
        w_nextState    = r_state;
        w_advance      = 1'b0;
        w_latchErr     = 1'b0;
        w_latchTimeout = 1'b0;
        case (r_state)
            LOAD: begin
                if (start) begin
                    // A same-cycle load counts, so the table is only empty
                    // when nothing was loaded before or during this cycle.
                    w_nextState = ((r_loadCount == '0) && !w_doWrite) ? PASS : RUN;
                end
            end
            RUN: begin
                if (w_match && w_lastEntry) begin
                    w_nextState = PASS;
                end
`ifdef STC_TIMEOUT_EN
                else if (w_timeoutHit) begin
                    w_nextState    = FAIL;
                    w_latchTimeout = 1'b1;
                end
`endif
                else if (w_match) begin
                    w_advance = 1'b1;
                end
                else if (memwrite && !w_ignore) begin
                    w_nextState = FAIL;
                    w_latchErr  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD;
            r_loadCount  <= '0;
            r_ptr        <= '0;
            r_cycleCount <= '0;
            r_errIndex   <= '0;
            r_errAddr    <= '0;
            r_errData    <= '0;
`ifdef STC_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            if (w_doWrite) begin
                r_loadCount <= r_loadCount + 1'b1;
            end
            if ((r_state == LOAD) && start) begin
                r_ptr <= '0;
            end else if (w_advance) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if ((r_state == RUN) && (r_cycleCount != 32'hFFFF_FFFF)) begin
                r_cycleCount <= r_cycleCount + 32'd1;
            end
            if (w_latchErr) begin
                r_errIndex <= r_ptr;
                r_errAddr  <= dataadr;
                r_errData  <= writedata;
            end
`ifdef STC_TIMEOUT_EN
            if (w_latchTimeout) begin
                r_timeout  <= 1'b1;
                r_errIndex <= r_ptr;
                r_errAddr  <= '0;
                r_errData  <= '0;
            end
`endif
        end
    end

    // Trace storage carries no reset; contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_tblAddr[r_loadCount[c_IDX_W-1:0]] <= exp_addr;
            r_tblData[r_loadCount[c_IDX_W-1:0]] <= exp_data;
        end
    end

    assign done        = (r_state == PASS) || (r_state == FAIL);
    assign pass        = (r_state == PASS);
    assign fail        = (r_state == FAIL);
    assign err_index   = r_errIndex;
    assign err_addr    = r_errAddr;
    assign err_data    = r_errData;
    assign cycle_count = r_cycleCount;

endmodule
`default_nettype wire

// File: tb/tb_store_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_trace_checker
// Description : Scoreboard bench for store_trace_checker.  A trace-level
//               reference model predicts each verdict; a monitor pops the
//               prediction when the DUT raises done.  A second instance with
//               the ignore rule disabled is checked against the same model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_trace_checker;

    localparam int DEPTH = 8;

    typedef struct {
        bit          decided;
        bit          pass;
        logic [31:0] idx;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cycles;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        start = 1'b0;

    logic        aFull, aDone, aPass, aFail, aTimeout;
    logic [2:0]  aErrIndex;
    logic [31:0] aErrAddr, aErrData, aCycles;
    logic        bFull, bDone, bPass, bFail, bTimeout;
    logic [2:0]  bErrIndex;
    logic [31:0] bErrAddr, bErrData, bCycles;

    int checks = 0;
    int errors = 0;

    logic [31:0] expA[$], expD[$], stA[$], stD[$];
    bit          stW[$];
    res_t        sbq[$];

    always #5 clk = ~clk;

    store_trace_checker #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .start(start), .exp_full(aFull), .done(aDone),
        .pass(aPass), .fail(aFail), .timeout(aTimeout), .err_index(aErrIndex),
        .err_addr(aErrAddr), .err_data(aErrData), .cycle_count(aCycles)
    );

    store_trace_checker #(.DEPTH(DEPTH), .IGNORE_VALID(1'b0)) dutNoIgn (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .start(start), .exp_full(bFull), .done(bDone),
        .pass(bPass), .fail(bFail), .timeout(bTimeout), .err_index(bErrIndex),
        .err_addr(bErrAddr), .err_data(bErrData), .cycle_count(bCycles)
    );

`ifdef STC_TIMEOUT_EN
    logic        cFull, cDone, cPass, cFail, cTimeout;
    logic [2:0]  cErrIndex;
    logic [31:0] cErrAddr, cErrData, cCycles;
    store_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(32'd20)) dutTo (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .start(start), .exp_full(cFull), .done(cDone),
        .pass(cPass), .fail(cFail), .timeout(cTimeout), .err_index(cErrIndex),
        .err_addr(cErrAddr), .err_data(cErrData), .cycle_count(cCycles)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearAll();
        expA.delete(); expD.delete(); stA.delete(); stD.delete(); stW.delete();
    endtask

    task automatic addStore(input bit w, input logic [31:0] a, input logic [31:0] d);
        stW.push_back(w); stA.push_back(a); stD.push_back(d);
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) addStore(1'b0, $urandom, $urandom);
    endtask

    // Walks the store list with the checker's rules: in-order match,
    // optional scratch-address skip, anything else is a failure.
    function automatic res_t model(input bit ign);
        res_t r;
        int   n;
        int   ptr;
        r.decided = 0; r.pass = 0; r.idx = 0; r.addr = 0; r.data = 0; r.cycles = 0;
        n = (expA.size() > DEPTH) ? DEPTH : expA.size();
        if (n == 0) begin
            r.decided = 1; r.pass = 1;
            return r;
        end
        ptr = 0;
        for (int k = 0; k < stA.size(); k++) begin
            if (!r.decided && stW[k]) begin
                if (stA[k] == expA[ptr] && stD[k] == expD[ptr]) begin
                    ptr++;
                    if (ptr == n) begin
                        r.decided = 1; r.pass = 1; r.cycles = k + 1;
                    end
                end else if (!(ign && stA[k] == 32'd80)) begin
                    r.decided = 1; r.idx = ptr; r.addr = stA[k]; r.data = stD[k];
                    r.cycles = k + 1;
                end
            end
        end
        if (!r.decided) r.cycles = stA.size();
        return r;
    endfunction

    // Monitor: compare the oldest prediction when done rises.
    bit seen = 0;
    always @(negedge clk) begin
        res_t r;
        if (!aDone) begin
            seen = 0;
        end else if (!seen) begin
            seen = 1;
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpectedVerdict: got pass=%0d fail=%0d with nothing predicted", aPass, aFail);
            end else begin
                r = sbq.pop_front();
                check("pass",     aPass,     r.pass);
                check("fail",     aFail,     !r.pass);
                check("errIndex", aErrIndex, r.idx);
                check("errAddr",  aErrAddr,  r.addr);
                check("errData",  aErrData,  r.data);
                check("cycles",   aCycles,   r.cycles);
                check("timeout",  aTimeout,  0);
            end
        end
    end

    task automatic runScenario(input bit combineStart);
        res_t r1, r2;
        bit   comb;
        r1 = model(1'b1);
        r2 = model(1'b0);
        comb = combineStart && expA.size() > 0 && expA.size() <= DEPTH;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        if (r1.decided) sbq.push_back(r1);
        for (int i = 0; i < expA.size(); i++) begin
            exp_we = 1'b1; exp_addr = expA[i]; exp_data = expD[i];
            start = comb && (i == expA.size() - 1);
            tick();
        end
        exp_we = 1'b0; start = 1'b0;
        check("expFull", aFull, (expA.size() >= DEPTH));
        if (!comb) begin
            start = 1'b1; tick(); start = 1'b0;
        end
        for (int k = 0; k < stA.size(); k++) begin
            memwrite = stW[k]; dataadr = stA[k]; writedata = stD[k];
            // Loads and start pulses outside LOAD must have no effect.
            exp_we = ($urandom_range(0, 3) == 0); exp_addr = $urandom; exp_data = $urandom;
            start = ($urandom_range(0, 7) == 0);
            tick();
        end
        memwrite = 1'b0; exp_we = 1'b0; start = 1'b0;
        check("doneEnd",   aDone,    r1.decided);
        check("cyclesEnd", aCycles,  r1.cycles);
        check("timeoutA",  aTimeout, 0);
        if (r1.decided) check("verdictSeen", sbq.size(), 0);
        check("nDone",     bDone,     r2.decided);
        check("nPass",     bPass,     r2.decided && r2.pass);
        check("nFail",     bFail,     r2.decided && !r2.pass);
        check("nErrIndex", bErrIndex, r2.idx);
        check("nErrAddr",  bErrAddr,  r2.addr);
        check("nErrData",  bErrData,  r2.data);
        check("nCycles",   bCycles,   r2.cycles);
        sbq.delete();
    endtask

    task automatic genRandom();
        logic [31:0] d;
        int          n;
        clearAll();
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) begin
            expA.push_back(($urandom_range(0, 5) == 0) ? 32'd80 : 32'(4 * $urandom_range(16, 23)));
            expD.push_back(32'($urandom_range(0, 3)));
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) addIdle(1);
            if ($urandom_range(0, 3) == 0) addStore(1'b1, 32'd80, 32'($urandom_range(0, 3)));
            d = expD[i];
            if ($urandom_range(0, 9) == 0) d = d + 32'd1;
            addStore(1'b1, expA[i], d);
        end
        addIdle(3);
    endtask

    initial begin
        res_t r;

        // Single entry preceded by a scratch write.
        clearAll();
        expA.push_back(84); expD.push_back(11497);
        addStore(1, 80, 7); addStore(1, 84, 11497); addIdle(3);
        runScenario(0);

        // Data mismatch, entry loaded in the same cycle as start.
        clearAll();
        expA.push_back(84); expD.push_back(11497);
        addStore(1, 84, 11496); addIdle(3);
        runScenario(1);

        // Full table plus an ignored ninth load, stores in order.
        clearAll();
        for (int i = 0; i < DEPTH + 1; i++) begin
            expA.push_back(84 + 4 * i); expD.push_back(100 + i);
        end
        for (int i = 0; i < DEPTH; i++) addStore(1, 84 + 4 * i, 100 + i);
        addIdle(3);
        runScenario(0);

        // Same table, stores reversed.
        stA.delete(); stD.delete(); stW.delete();
        for (int i = DEPTH - 1; i >= 0; i--) addStore(1, 84 + 4 * i, 100 + i);
        addIdle(3);
        runScenario(0);

        // Empty table.
        clearAll();
        addIdle(3);
        runScenario(0);

        // Reset in the middle of RUN.
        clearAll();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_we = 1'b1; exp_addr = 84 + 4 * i; exp_data = i; tick();
        end
        exp_we = 1'b0; start = 1'b1; tick(); start = 1'b0;
        memwrite = 1'b1; dataadr = 84; writedata = 0; tick(); memwrite = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("rstDone",   aDone,     0);
        check("rstPass",   aPass,     0);
        check("rstFail",   aFail,     0);
        check("rstFull",   aFull,     0);
        check("rstCycles", aCycles,   0);
        check("rstIndex",  aErrIndex, 0);
        r.decided = 1; r.pass = 1; r.idx = 0; r.addr = 0; r.data = 0; r.cycles = 0;
        sbq.push_back(r);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("rstLoadState", sbq.size(), 0);
        check("rstThenPass",  aPass,      1);
        sbq.delete();

        // Scratch write is a failure when the ignore rule is off.
        clearAll();
        expA.push_back(84); expD.push_back(1);
        addStore(1, 80, 5); addIdle(3);
        runScenario(0);

        // No stores at all: no verdict without a watchdog.
        clearAll();
        expA.push_back(84); expD.push_back(1);
        addIdle(100);
        runScenario(0);
`ifdef STC_TIMEOUT_EN
        check("toFail",    cFail,     1);
        check("toTimeout", cTimeout,  1);
        check("toCycles",  cCycles,   20);
        check("toIndex",   cErrIndex, 0);
        check("toAddr",    cErrAddr,  0);
`endif

        for (int s = 0; s < 30; s++) begin
            genRandom();
            runScenario($urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
